pwm_multi_channel_generator: RTL

Generates NUM_CHANNELS synchronised ESC/servo PWM outputs from a single free-running period counter on the 1 MHz microsecond clock. Each pulse is a fixed minimum high time plus a per-channel commanded value, clamped to a maximum. The block also provides double-buffered command updates applied only at period boundaries, arm and per-channel enable gating, and a command-loss failsafe. It sits between the flight-control output stage and the motor pins, replacing per-motor single-channel generators.

---
 rtl/pwm_multi_channel_generator.sv | 116 +++++++++++
 1 files changed

// File: rtl/pwm_multi_channel_generator.sv
// Multi-channel ESC/servo PWM generator: one shared period counter, double-buffered
// commands applied at period boundaries, arm/enable gating and a command-loss failsafe.
module pwm_multi_channel_generator #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned VAL_WIDTH       = 10,
  parameter int unsigned PERIOD_US       = 20000,
  parameter int unsigned MIN_HIGH_US     = 1000,
  parameter int unsigned MAX_HIGH_US     = 2000,
  parameter int unsigned TIMEOUT_PERIODS = 10
) (
  input  logic                              us_clk,
  input  logic                              resetn,
  input  logic [NUM_CHANNELS*VAL_WIDTH-1:0] motor_vals,
  input  logic                              update_valid,
  input  logic                              arm,
  input  logic [NUM_CHANNELS-1:0]           chan_en,
  output logic [NUM_CHANNELS-1:0]           motor_pwm,
  output logic                              period_start,
  output logic                              failsafe
);

  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_US - 1);
  localparam logic [15:0] MIN_HIGH    = 16'(MIN_HIGH_US);
  localparam logic [15:0] CMD_RANGE   = 16'(MAX_HIGH_US - MIN_HIGH_US);
  localparam logic [15:0] TIMEOUT     = 16'(TIMEOUT_PERIODS);

  logic [15:0]          cnt;
  logic [15:0]          cnt_next;
  logic                 wrap;
  logic [VAL_WIDTH-1:0] shadow [NUM_CHANNELS];
  logic [15:0]          active [NUM_CHANNELS];
  logic [15:0]          load_val [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] en_lat;
  logic [NUM_CHANNELS-1:0] pwm_d;
  logic [15:0]          wd_cnt;
  logic [15:0]          wd_next;
  logic                 failsafe_next;

  assign wrap     = (cnt == PERIOD_LAST);
  assign cnt_next = wrap ? 16'd0 : cnt + 16'd1;

  // Watchdog: an update always wins over a coincident period-start increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wd_next       = wd_cnt;
    failsafe_next = failsafe;
    if (update_valid) begin
      wd_next       = 16'd0;
      failsafe_next = 1'b0;
    end else if (wrap && (wd_cnt != TIMEOUT)) begin
      wd_next = wd_cnt + 16'd1;
      if ((TIMEOUT != 16'd0) && (wd_cnt + 16'd1 == TIMEOUT))
        failsafe_next = 1'b1;
    end
  end

  // Value the active registers take at the next period start; clamp precedes the add.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      load_val[i] = 16'd0;
      if (arm && !failsafe_next)
        load_val[i] = (16'(shadow[i]) > CMD_RANGE) ? CMD_RANGE : 16'(shadow[i]);
    end
  end

  // Next output level: at the wrap edge use the freshly loaded width and enable,
  // otherwise the ones latched for the period in progress.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (wrap)
        pwm_d[i] = chan_en[i] && (cnt_next < MIN_HIGH + load_val[i]);
      else
        pwm_d[i] = en_lat[i] && (cnt_next < MIN_HIGH + active[i]);
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the reset value makes the first edge after release a period start.
      cnt          <= PERIOD_LAST;
      period_start <= 1'b0;
      motor_pwm    <= '0;
      failsafe     <= 1'b0;
      wd_cnt       <= 16'd0;
      en_lat       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      cnt          <= cnt_next;
      period_start <= wrap;
      motor_pwm    <= pwm_d;
      failsafe     <= failsafe_next;
      wd_cnt       <= wd_next;
      if (wrap)
        en_lat <= chan_en;
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the per-channel command registers are reset because a reset must fall back to minimum pulses.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (update_valid)
          shadow[i] <= motor_vals[i*VAL_WIDTH +: VAL_WIDTH];
        if (wrap)
          active[i] <= load_val[i];
      end
    end
  end

endmodule
